demod_bus_arbiter: RTL and testbench
====================================

// Module: demod_bus_arbiter
// PURPOSE
//  Arbitrates the demod register bus (cs, wr0..wr3, addr, dataIn/dataOut) between two requesters:
//  req0 = host processor bridge, req1 = internal lock supervisor (falseLock/AMTC retuning).
//  Sequences each granted access into a setup/strobe/ack cycle so that the byte-lane write strobes
//  and the combinational read path of the demod register bank are always driven by exactly one master.
// PARAMETERS
//  ADDR_W         13  register address width
//  SETUP_CYCLES    1  cycles cs+addr held before strobe/sample (1..15)
//  STROBE_CYCLES   1  cycles wrN held high on a write (1..15)
// PORTS
//  busClk        in   1       register bus clock; all logic rising-edge
//  resetN        in   1       async assert, active-low; sync deassert done upstream
//  reqN[1:0]     in   2       access request per requester, level, held until ackN
//  weN[1:0]      in   2       1=write 0=read, per requester
//  beN0/beN1     in   4 each  byte enables, requester 0/1 (bit k -> wrk)
//  addrN0/addrN1 in   ADDR_W  register address, requester 0/1
//  wdataN0/1     in   32      write data, requester 0/1
//  ack[1:0]      out  2       one-cycle completion pulse to granted requester
//  rdata         out  32      read data, valid only on the ack cycle of a read
//  busy          out  1       high from grant through ack
//  grant[1:0]    out  2       one-hot current owner, 0 when IDLE
//  cs            out  1       to register bank
//  wr0..wr3      out  1 each  byte-lane write strobes, active-high, to register bank
//  addr          out  ADDR_W  to register bank
//  dataIn        out  32      write data to register bank
//  dataOut       in   32      read data from register bank (combinational)
// BEHAVIOUR
//  Reset (async, resetN=0): state IDLE; cs, wr0..3, ack, grant, busy = 0; addr, dataIn, rdata = 0;
//   rrLast = 1 (so requester 0 wins the first tie). Effective immediately, incl. mid-transaction;
//   an interrupted access is dropped, no ack is issued.
//  States: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
//  IDLE: if any reqN, grant per round-robin: both pending -> the one != rrLast; else the single one.
//   Latch owner's we/be/addr/wdata into holding regs; grant, busy = 1; rrLast <= owner; go SETUP.
//  SETUP: cs=1, addr/dataIn from holding regs, wr*=0; count SETUP_CYCLES cycles, then STROBE.
//  STROBE write: wrk = be[k] for STROBE_CYCLES cycles, cs and addr stable throughout.
//   be=4'b0000 write: no strobe, still acked.
//  STROBE read: single cycle, wr*=0; rdata <= dataOut at end of cycle.
//  ACK: cs=0, wr*=0; ack[owner]=1 for exactly one cycle; grant, busy cleared on exit; go IDLE.
//  Total latency grant->ack: write 1+SETUP+STROBE cycles (3 at default); read 1+SETUP+1 (3).
//  Minimum gap: IDLE spends >=1 cycle between transactions, so back-to-back alternating requests
//   run every 4 cycles at defaults.
//  Request fields are sampled only at grant; changes afterwards are ignored.
//  reqN dropped mid-access: access completes on the bus, ack still pulsed (requester ignores).
//  Requester must deassert reqN on the ack cycle; if still high in the next IDLE it is a new request.
//  addr/dataIn hold last value in IDLE; cs low guarantees the bank ignores them.
//  No two wr strobes from different owners ever overlap; cs never high in IDLE or ACK.
// STRUCTURE
//  Package demod_bus_pkg: state encoding (IDLE/SETUP/STROBE/ACK), ADDR_W default, cycle-count width.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], rrLast, advance -> grant one-hot).
//  Remainder (FSM, counter, holding regs, rdata capture) lives in demod_bus_arbiter.
// TESTING
//  1 Reset mid-STROBE of req0 write be=4'hF -> cs, wr0..3 drop same cycle; no ack[0]; grant=0.
//  2 req0 write addr=DEMOD_DACSELECT be=4'b0110 data=32'h000A0B0C -> wr1,wr2 high 1 cycle, wr0/wr3 low;
//    ack[0] 3 cycles after grant.
//  3 req1 read DEMOD_FALSELOCK, bank returns 32'h12345678 -> rdata=32'h12345678 with ack[1], cs low on ack.
//  4 req0 and req1 asserted same cycle after reset, held -> grants 0,1,0,1; acks every 4 cycles.
//  5 SETUP_CYCLES=3, STROBE_CYCLES=2 write -> cs high 5 cycles, wrN high last 2, ack 6 cycles after grant.
//  6 req0 changes addr/wdata during SETUP -> bus shows grant-time values; be=0 write acked, no strobes.

Source files
------------

// File: rtl/demod_bus_pkg.sv
// demod_bus_pkg: shared state encoding and sizing for the demod register bus arbiter.
package demod_bus_pkg;
   localparam int ADDR_W_DEF = 13;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_ACK} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_last,
   input  logic       advance,
   output logic [1:0] grant
);
   assign grant = !advance ? 2'b00 : (&req) ? (rr_last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/demod_bus_arbiter.sv
// demod_bus_arbiter: shares the demod register bus between the host bridge and the lock supervisor,
// running each granted access as setup / strobe / ack so only one master ever drives the bank.
module demod_bus_arbiter
   import demod_bus_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 1
) (
   input  logic              busClk,
   input  logic              resetN,
   input  logic [1:0]        reqN,
   input  logic [1:0]        weN,
   input  logic [3:0]        beN0,
   input  logic [3:0]        beN1,
   input  logic [ADDR_W-1:0] addrN0,
   input  logic [ADDR_W-1:0] addrN1,
   input  logic [31:0]       wdataN0,
   input  logic [31:0]       wdataN1,
   output logic [1:0]        ack,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic [1:0]        grant,
   output logic              cs,
   output logic              wr0,
   output logic              wr1,
   output logic              wr2,
   output logic              wr3,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       dataIn,
   input  logic [31:0]       dataOut
);
   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                rr_last_q, rr_last_d;
   logic [1:0]          arb_grant;

   rr_arb2 u_arb (
      .req     (reqN),
      .rr_last (rr_last_q),
      .advance (state_q == ST_IDLE),
      .grant   (arb_grant)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rr_last_d = rr_last_q;
      case (state_q)
         ST_IDLE: if (|arb_grant) begin
            owner_d   = arb_grant[1];
            we_d      = weN[arb_grant[1]];
            be_d      = arb_grant[1] ? beN1 : beN0;
            addr_d    = arb_grant[1] ? addrN1 : addrN0;
            wdata_d   = arb_grant[1] ? wdataN1 : wdataN0;
            rr_last_d = arb_grant[1];
            cnt_d     = '0;
            state_d   = ST_SETUP;
         end
         ST_SETUP: begin
            cnt_d   = (cnt_q == SETUP_LAST) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == SETUP_LAST) ? ST_STROBE : ST_SETUP;
         end
         ST_STROBE: begin
            // reads take one strobe cycle and sample the bank's combinational data at its end
            rdata_d = we_q ? rdata_q : dataOut;
            cnt_d   = cnt_q + 1'b1;
            state_d = (!we_q || cnt_q == STROBE_LAST) ? ST_ACK : ST_STROBE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge busClk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rr_last_q <= rr_last_d;
      end
   end

   // bus controls decode straight from state so an async reset drops them immediately
   assign busy   = state_q != ST_IDLE;
   assign grant  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign ack    = (state_q == ST_ACK) ? grant : 2'b00;
   assign cs     = (state_q == ST_SETUP) || (state_q == ST_STROBE);
   assign {wr3, wr2, wr1, wr0} = (state_q == ST_STROBE && we_q) ? be_q : 4'b0000;
   assign addr   = addr_q;
   assign dataIn = wdata_q;
   assign rdata  = rdata_q;
endmodule

// File: tb/tb_demod_bus_arbiter.sv
// tb_demod_bus_arbiter: directed checks of arbitration, access sequencing, reset and timing.
module tb_demod_bus_arbiter;
   localparam logic [12:0] DEMOD_DACSELECT = 13'h0040;
   localparam logic [12:0] DEMOD_FALSELOCK = 13'h0014;

   logic        busClk = 1'b0;
   logic        resetN = 1'b0;
   logic [1:0]  reqN = '0, weN = '0, reqN_b = '0;
   logic [3:0]  beN0 = '0, beN1 = '0;
   logic [12:0] addrN0 = '0, addrN1 = '0;
   logic [31:0] wdataN0 = '0, wdataN1 = '0;
   logic [1:0]  ack, grant, ack_b, grant_b;
   logic [31:0] rdata, dataIn, dataOut, rdata_b, dataIn_b;
   logic        busy, cs, wr0, wr1, wr2, wr3, busy_b, cs_b, wrb0, wrb1, wrb2, wrb3;
   logic [12:0] addr, addr_b;
   logic [3:0]  wr, wr_b;
   int          n_cmp = 0, n_err = 0;

   assign wr      = {wr3, wr2, wr1, wr0};
   assign wr_b    = {wrb3, wrb2, wrb1, wrb0};
   // register bank model: FALSELOCK returns a fixed pattern, everything else echoes its address
   assign dataOut = (addr == DEMOD_FALSELOCK) ? 32'h12345678 : {19'b0, addr};

   always #5 busClk = ~busClk;

   demod_bus_arbiter dut (
      .busClk(busClk), .resetN(resetN), .reqN(reqN), .weN(weN), .beN0(beN0), .beN1(beN1),
      .addrN0(addrN0), .addrN1(addrN1), .wdataN0(wdataN0), .wdataN1(wdataN1),
      .ack(ack), .rdata(rdata), .busy(busy), .grant(grant), .cs(cs),
      .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3), .addr(addr), .dataIn(dataIn), .dataOut(dataOut)
   );

   demod_bus_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut_long (
      .busClk(busClk), .resetN(resetN), .reqN(reqN_b), .weN(weN), .beN0(beN0), .beN1(beN1),
      .addrN0(addrN0), .addrN1(addrN1), .wdataN0(wdataN0), .wdataN1(wdataN1),
      .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .grant(grant_b), .cs(cs_b),
      .wr0(wrb0), .wr1(wrb1), .wr2(wrb2), .wr3(wrb3), .addr(addr_b), .dataIn(dataIn_b),
      .dataOut(32'h0)
   );

   task automatic tick();
      @(posedge busClk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      n_cmp++; if ({cs, wr, ack, grant, busy} !== 10'b0) begin n_err++; $display("FAIL reset_ctrl: cs/wr/ack/grant/busy=%b want 0", {cs, wr, ack, grant, busy}); end
      n_cmp++; if ({addr, dataIn, rdata} !== 77'b0) begin n_err++; $display("FAIL reset_data: addr=%h dataIn=%h rdata=%h want 0", addr, dataIn, rdata); end
      resetN = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_strobe();
      int acks = 0;
      reqN = 2'b01; weN = 2'b01; beN0 = 4'hF; addrN0 = 13'h0007; wdataN0 = 32'hDEADBEEF;
      tick(); tick();
      n_cmp++; if ({cs, wr} !== 5'b11111) begin n_err++; $display("FAIL rst_mid_strobe: cs,wr=%b want 11111", {cs, wr}); end
      resetN = 1'b0;
      #1;
      n_cmp++; if ({cs, wr, grant, busy} !== 8'b0) begin n_err++; $display("FAIL rst_mid_drop: cs,wr,grant,busy=%b want 0", {cs, wr, grant, busy}); end
      reqN = 2'b00;
      for (int i = 0; i < 3; i++) begin tick(); if (ack != 2'b00) acks++; end
      resetN = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); if (ack != 2'b00) acks++; end
      n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rst_mid_noack: acks=%0d want 0", acks); end
   endtask

   task automatic test_write();
      reqN = 2'b01; weN = 2'b01; beN0 = 4'b0110; addrN0 = DEMOD_DACSELECT; wdataN0 = 32'h000A0B0C;
      tick();
      n_cmp++; if ({grant, busy, cs, wr} !== 8'b01_1_1_0000) begin n_err++; $display("FAIL wr_setup: grant,busy,cs,wr=%b want 01110000", {grant, busy, cs, wr}); end
      n_cmp++; if (addr !== DEMOD_DACSELECT || dataIn !== 32'h000A0B0C) begin n_err++; $display("FAIL wr_bus: addr=%h dataIn=%h want %h 000a0b0c", addr, dataIn, DEMOD_DACSELECT); end
      tick();
      n_cmp++; if ({cs, wr, ack} !== 7'b1_0110_00) begin n_err++; $display("FAIL wr_strobe: cs,wr,ack=%b want 1011000", {cs, wr, ack}); end
      tick();
      n_cmp++; if ({ack, cs, wr} !== 7'b01_0_0000) begin n_err++; $display("FAIL wr_ack: ack,cs,wr=%b want 0100000", {ack, cs, wr}); end
      reqN = 2'b00;
      tick();
      n_cmp++; if ({ack, grant, busy} !== 5'b0 || addr !== DEMOD_DACSELECT) begin n_err++; $display("FAIL wr_idle: ack,grant,busy=%b addr=%h want 0 / %h", {ack, grant, busy}, addr, DEMOD_DACSELECT); end
   endtask

   task automatic test_read();
      reqN = 2'b10; weN = 2'b00; addrN1 = DEMOD_FALSELOCK; beN1 = 4'hF;
      tick();
      n_cmp++; if ({grant, cs, wr} !== 7'b10_1_0000 || addr !== DEMOD_FALSELOCK) begin n_err++; $display("FAIL rd_setup: grant,cs,wr=%b addr=%h want 1010000 / %h", {grant, cs, wr}, addr, DEMOD_FALSELOCK); end
      tick();
      n_cmp++; if ({cs, wr} !== 5'b1_0000) begin n_err++; $display("FAIL rd_strobe: cs,wr=%b want 10000", {cs, wr}); end
      tick();
      n_cmp++; if (ack !== 2'b10 || cs !== 1'b0) begin n_err++; $display("FAIL rd_ack: ack=%b cs=%b want 10 0", ack, cs); end
      n_cmp++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_data: rdata=%h want 12345678", rdata); end
      reqN = 2'b00;
      tick();
   endtask

   task automatic test_back_to_back();
      int na = 0;
      int at[4];
      logic [1:0] own[4];
      logic [31:0] rd0 = '0;
      resetN = 1'b0; tick(); resetN = 1'b1; tick();
      reqN = 2'b11; weN = 2'b00; addrN0 = 13'h0001; addrN1 = 13'h0002;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (ack != 2'b00) begin
            if (na < 4) begin at[na] = i; own[na] = ack; end
            if (na == 0) rd0 = rdata;
            na++;
         end
         if (i == 16) reqN = 2'b00;
      end
      n_cmp++; if (na !== 4) begin n_err++; $display("FAIL b2b_count: acks=%0d want 4", na); end
      for (int k = 0; k < 4 && k < na; k++) begin
         n_cmp++; if (at[k] !== 3 + 4 * k) begin n_err++; $display("FAIL b2b_time%0d: cycle=%0d want %0d", k, at[k], 3 + 4 * k); end
         n_cmp++; if (own[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL b2b_owner%0d: ack=%b want %b", k, own[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
      end
      n_cmp++; if (rd0 !== 32'h1) begin n_err++; $display("FAIL b2b_rdata: rdata=%h want 00000001", rd0); end
      tick();
   endtask

   task automatic test_field_change();
      reqN = 2'b01; weN = 2'b01; beN0 = 4'b0000; addrN0 = 13'h0ABC; wdataN0 = 32'h11112222;
      tick();
      addrN0 = 13'h1555; wdataN0 = 32'h99998888; beN0 = 4'hF;
      tick();
      n_cmp++; if (addr !== 13'h0ABC || dataIn !== 32'h11112222) begin n_err++; $display("FAIL chg_bus: addr=%h dataIn=%h want 0abc 11112222", addr, dataIn); end
      n_cmp++; if ({cs, wr} !== 5'b1_0000) begin n_err++; $display("FAIL chg_nostrobe: cs,wr=%b want 10000", {cs, wr}); end
      tick();
      n_cmp++; if (ack !== 2'b01 || wr !== 4'b0000) begin n_err++; $display("FAIL chg_ack: ack=%b wr=%b want 01 0000", ack, wr); end
      reqN = 2'b00;
      tick();
   endtask

   task automatic test_long_timing();
      int bad = 0;
      reqN_b = 2'b01; weN = 2'b01; beN0 = 4'hF; addrN0 = 13'h0123; wdataN0 = 32'hCAFEF00D;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_cmp++;
         if (cs_b !== (i <= 5) || wr_b !== ((i == 4 || i == 5) ? 4'hF : 4'h0) || ack_b !== ((i == 6) ? 2'b01 : 2'b00)) begin
            n_err++; bad++;
            $display("FAIL long_cycle%0d: cs=%b wr=%b ack=%b want cs=%b wr=%h ack=%b", i, cs_b, wr_b, ack_b, i <= 5, (i == 4 || i == 5) ? 4'hF : 4'h0, (i == 6) ? 2'b01 : 2'b00);
         end
         if (i == 6) reqN_b = 2'b00;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_reset_mid_strobe();
      test_write();
      test_read();
      test_back_to_back();
      test_field_change();
      test_long_timing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
